// File: rtl/src_wakeup_array_if.sv
// rtl/src_wakeup_array_if.sv - allocate/free/flush, writeback snoop and read port bundle for src_wakeup_array
interface src_wakeup_array_if #(
  parameter int DATA_LEN = 32,
  parameter int RRF_SEL  = 6,
  parameter int NUM_BUS  = 5,
  parameter int DEPTH    = 8,
  parameter int ENT_SEL  = $clog2(DEPTH)
);
  logic                         flush;
  logic                         alloc_en;
  logic [ENT_SEL-1:0]           alloc_idx;
  logic [DATA_LEN-1:0]          alloc_opr;
  logic                         alloc_rdy;
  logic                         free_en;
  logic [ENT_SEL-1:0]           free_idx;
  logic [NUM_BUS-1:0]           exvalid;
  logic [NUM_BUS-1:0]           kill_spec;
  logic [NUM_BUS*RRF_SEL-1:0]   exdst;
  logic [NUM_BUS*DATA_LEN-1:0]  exrslt;
  logic [ENT_SEL-1:0]           rd_idx;
  logic [DATA_LEN-1:0]          rd_src;
  logic                         rd_resolved;
  logic [DEPTH-1:0]             busy_vec;
  logic [DEPTH-1:0]             resolved_vec;
  logic [ENT_SEL:0]             busy_cnt;
  logic                         err_alloc_busy;

  // Issue/rename side drives control, buses and read index.
  modport master (
    output flush, alloc_en, alloc_idx, alloc_opr, alloc_rdy, free_en, free_idx,
    output exvalid, kill_spec, exdst, exrslt, rd_idx,
    input  rd_src, rd_resolved, busy_vec, resolved_vec, busy_cnt, err_alloc_busy
  );

  // The array itself.
  modport slave (
    input  flush, alloc_en, alloc_idx, alloc_opr, alloc_rdy, free_en, free_idx,
    input  exvalid, kill_spec, exdst, exrslt, rd_idx,
    output rd_src, rd_resolved, busy_vec, resolved_vec, busy_cnt, err_alloc_busy
  );
endinterface

// File: rtl/src_wakeup_array.sv
// rtl/src_wakeup_array.sv - reservation-station source operand capture array; optional macro SRC_WAKEUP_BYPASS_EN adds zero-cycle wakeup on read outputs
module src_wakeup_array #(
  parameter int DATA_LEN = 32,
  parameter int RRF_SEL  = 6,
  parameter int NUM_BUS  = 5,
  parameter int DEPTH    = 8,
  parameter int ENT_SEL  = $clog2(DEPTH)
) (
  input logic                 clk,
  input logic                 reset,
  src_wakeup_array_if.slave   sif
);

  // Per-entry registered state
  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    rdy_q, rdy_d;
  logic [DATA_LEN-1:0] val_q [DEPTH];
  logic [DATA_LEN-1:0] val_d [DEPTH];
  logic                err_q, err_d;

  // Snoop results: per registered entry and for the tag being allocated
  logic [DEPTH-1:0]    hit;
  logic [DATA_LEN-1:0] hit_data [DEPTH];
  logic                alloc_hit;
  logic [DATA_LEN-1:0] alloc_hit_data;
  logic [RRF_SEL-1:0]  alloc_tag;

  // Entries that are pending in registered state and being woken this cycle
  logic [DEPTH-1:0]    wake;

  logic                same_idx_free;

  assign alloc_tag     = sif.alloc_opr[RRF_SEL-1:0];
  assign same_idx_free = sif.free_en && (sif.free_idx == sif.alloc_idx);

  // Tag match against every bus; scanning high to low leaves the lowest-index hit as the winner
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      hit[e]      = 1'b0;
      hit_data[e] = '0;
      for (int j = NUM_BUS - 1; j >= 0; j--) begin
        if (sif.exvalid[j] && !sif.kill_spec[j] &&
            (sif.exdst[j*RRF_SEL +: RRF_SEL] == val_q[e][RRF_SEL-1:0])) begin
          hit[e]      = 1'b1;
          hit_data[e] = sif.exrslt[j*DATA_LEN +: DATA_LEN];
        end
      end
    end
  end

  // Same-cycle match for a pending allocation so a broadcast coinciding with allocate is not lost
  always_comb begin
    alloc_hit      = 1'b0;
    alloc_hit_data = '0;
    for (int j = NUM_BUS - 1; j >= 0; j--) begin
      if (sif.exvalid[j] && !sif.kill_spec[j] &&
          (sif.exdst[j*RRF_SEL +: RRF_SEL] == alloc_tag)) begin
        alloc_hit      = 1'b1;
        alloc_hit_data = sif.exrslt[j*DATA_LEN +: DATA_LEN];
      end
    end
  end

  assign wake = valid_q & ~rdy_q & hit;

  // Next-state per entry: flush > alloc > free > snoop
  always_comb begin
    valid_d = valid_q;
    rdy_d   = rdy_q;
    for (int e = 0; e < DEPTH; e++) begin
      val_d[e] = val_q[e];
      if (sif.flush) begin
        valid_d[e] = 1'b0;
        rdy_d[e]   = 1'b0;
      end else if (sif.alloc_en && (sif.alloc_idx == ENT_SEL'(e))) begin
        valid_d[e] = 1'b1;
        if (sif.alloc_rdy) begin
          rdy_d[e] = 1'b1;
          val_d[e] = sif.alloc_opr;
        end else if (alloc_hit) begin
          rdy_d[e] = 1'b1;
          val_d[e] = alloc_hit_data;
        end else begin
          rdy_d[e] = 1'b0;
          val_d[e] = DATA_LEN'(alloc_tag);
        end
      end else if (sif.free_en && (sif.free_idx == ENT_SEL'(e))) begin
        valid_d[e] = 1'b0;
        rdy_d[e]   = 1'b0;
      end else if (wake[e]) begin
        rdy_d[e] = 1'b1;
        val_d[e] = hit_data[e];
      end
    end
  end

  // Sticky flag for allocating over a live entry that is not being released in the same cycle
  always_comb begin
    err_d = err_q;
    if (sif.alloc_en && valid_q[sif.alloc_idx] && !same_idx_free && !sif.flush) begin
      err_d = 1'b1;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      rdy_q   <= '0;
      err_q   <= 1'b0;
      for (int e = 0; e < DEPTH; e++) begin
        val_q[e] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
      for (int e = 0; e < DEPTH; e++) begin
        val_q[e] <= val_d[e];
      end
    end
  end

  // Occupancy count of registered valid bits
  always_comb begin
    sif.busy_cnt = '0;
    for (int e = 0; e < DEPTH; e++) begin
      sif.busy_cnt = sif.busy_cnt + {{ENT_SEL{1'b0}}, valid_q[e]};
    end
  end

  assign sif.busy_vec       = valid_q;
  assign sif.err_alloc_busy = err_q;

`ifdef SRC_WAKEUP_BYPASS_EN
  // Resolved view forwards same-cycle wakeups of registered pending entries
  always_comb begin
    sif.resolved_vec = (valid_q & rdy_q) | wake;
    sif.rd_resolved  = sif.resolved_vec[sif.rd_idx];
    sif.rd_src       = wake[sif.rd_idx] ? hit_data[sif.rd_idx] : val_q[sif.rd_idx];
  end
`else
  // Resolved view taken purely from registered state
  always_comb begin
    sif.resolved_vec = valid_q & rdy_q;
    sif.rd_resolved  = sif.resolved_vec[sif.rd_idx];
    sif.rd_src       = val_q[sif.rd_idx];
  end
`endif

endmodule
